// File: rtl/aes_key_expander.sv
// ============================================================================
//  Module   : aes_key_expander
//  Purpose  : Iterative AES-128/192/256 key schedule. One round-key word is
//             produced per clock into an internal store, which is read back
//             through a registered address/data port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
//  aes_sbox : single-byte AES S-box, computed as GF(2^8) inverse + affine map
// ----------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 (maps 0 to 0), then the FIPS-197 affine transform
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign s_o = sbox_f(a_i);

endmodule

// ----------------------------------------------------------------------------
//  aes_key_expander : top level
// ----------------------------------------------------------------------------
module aes_key_expander #(
  parameter int MAX_WORDS = 60,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [255:0]      key,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rk_valid,
  output logic [5:0]        num_words,
  input  logic [ADDR_W-1:0] rk_addr,
  output logic [31:0]       rk_word
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_EXPAND = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  nk_q;          // words in the cipher key: 4, 6 or 8
  logic [2:0]  cnt_q;         // i mod Nk, kept as a wrap counter
  logic [5:0]  idx_q;         // index i of the word written this cycle
  logic [7:0]  rcon_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        rk_valid_q;
  logic [5:0]  num_words_q;
  logic [31:0] rk_word_q;

  logic [31:0] store_q [MAX_WORDS];

  logic [3:0]  nk_start_d;
  logic [5:0]  nw_start_d;
  logic        accept_d;
  logic [31:0] prev_d;
  logic [31:0] back_d;
  logic [31:0] sub_in_d;
  logic [31:0] sub_out_d;
  logic [31:0] temp_d;
  logic [31:0] word_d;
  logic [7:0]  rcon_d;
  logic        last_d;
  logic        addr_ok_d;

  // Key size decode for a start request
  always_comb begin
    nk_start_d = 4'd4;
    nw_start_d = 6'd44;
    case (mode)
      2'd1:    begin nk_start_d = 4'd6; nw_start_d = 6'd52; end
      2'd2:    begin nk_start_d = 4'd8; nw_start_d = 6'd60; end
      default: begin nk_start_d = 4'd4; nw_start_d = 6'd44; end
    endcase
  end

  assign accept_d = (state_q == S_IDLE) && start && (mode != 2'd3);

  // w[i-1] feeds the transform, w[i-Nk] is the XOR partner
  assign prev_d   = store_q[idx_q - 6'd1];
  assign back_d   = store_q[idx_q - {2'b00, nk_q}];

  // The same four S-boxes serve both the RotWord and the plain SubWord case
  assign sub_in_d = (cnt_q == 3'd0) ? {prev_d[23:0], prev_d[31:24]} : prev_d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (sub_in_d[8*gi +: 8]),
      .s_o (sub_out_d[8*gi +: 8])
    );
  end

  // Select the per-word transform and form the new word
  always_comb begin
    temp_d = prev_d;
    if (cnt_q == 3'd0) begin
      temp_d = sub_out_d ^ {rcon_q, 24'h000000};
    end else if ((nk_q == 4'd8) && (cnt_q == 3'd4)) begin
      temp_d = sub_out_d;
    end
  end

  assign word_d    = back_d ^ temp_d;
  assign rcon_d    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  assign last_d    = (idx_q == (num_words_q - 6'd1));
  assign addr_ok_d = (32'(rk_addr) < 32'(num_words_q));

  // Control FSM: start acceptance, word indexing, rcon sequencing and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      nk_q        <= 4'd4;
      cnt_q       <= 3'd0;
      idx_q       <= 6'd0;
      rcon_q      <= 8'h01;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rk_valid_q  <= 1'b0;
      num_words_q <= 6'd44;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (mode == 2'd3) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= S_EXPAND;
              nk_q        <= nk_start_d;
              num_words_q <= nw_start_d;
              idx_q       <= {2'b00, nk_start_d};
              cnt_q       <= 3'd0;
              rcon_q      <= 8'h01;
              busy_q      <= 1'b1;
              rk_valid_q  <= 1'b0;
            end
          end
        end
        S_EXPAND: begin
          idx_q <= idx_q + 6'd1;
          cnt_q <= ({1'b0, cnt_q} == (nk_q - 4'd1)) ? 3'd0 : cnt_q + 3'd1;
          if (cnt_q == 3'd0) rcon_q <= rcon_d;
          if (last_d) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            rk_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Round-key store: key words land on the start edge, then one word per cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept_d) begin
        for (int j = 0; j < 8; j++) begin
          if (j[3:0] < nk_start_d) store_q[j[5:0]] <= key[255 - 32*j -: 32];
        end
      end else if (state_q == S_EXPAND) begin
        store_q[idx_q] <= word_d;
      end
    end
  end

  // Registered read port; addresses beyond the current schedule read as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_word_q <= 32'h0;
    end else begin
      rk_word_q <= addr_ok_d ? store_q[rk_addr] : 32'h0;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rk_valid  = rk_valid_q;
  assign num_words = num_words_q;
  assign rk_word   = rk_word_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expander.sv
// ============================================================================
//  Module   : tb_aes_key_expander
//  Purpose  : Self-checking bench for aes_key_expander: known-answer vectors
//             for all three key sizes, full read-port sweeps against a
//             software key schedule, and the multi-cycle corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key;
  logic [5:0]   rk_addr;
  logic         busy;
  logic         done;
  logic         err;
  logic         rk_valid;
  logic [5:0]   num_words;
  logic [31:0]  rk_word;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  sbox_tab [256];
  logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0] model_w  [64];
  int          model_nw;
  logic [31:0] sb_q [$];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                   128'hdeadbeef0badf00dcafebabe12345678};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                   64'hffffffff00000000};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    logic [1:0]   mode;
    logic [255:0] key;
    int           lat;
    int           nw;
    int           a0;
    logic [31:0]  w0;
    int           a1;
    logic [31:0]  w1;
    int           a2;
    logic [31:0]  w2;
  } vec_t;

  vec_t vecs [3];

  aes_key_expander #(.MAX_WORDS(60), .ADDR_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rk_valid  (rk_valid),
    .num_words (num_words),
    .rk_addr   (rk_addr),
    .rk_word   (rk_word)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Horner-form GF(2^8) product
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      r = xt(r);
      if (b[k]) r = r ^ a;
    end
    return r;
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      end
      for (int b = 0; b < 8; b++) begin
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      end
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Reference FIPS-197 key expansion
  task automatic build_model(input logic [1:0] m, input logic [255:0] k);
    int nk;
    logic [31:0] t;
    nk = (m == 2'd0) ? 4 : (m == 2'd1) ? 6 : 8;
    model_nw = 4 * (nk + 7);
    for (int i = 0; i < 64; i++) model_w[i] = 32'h0;
    for (int i = 0; i < nk; i++) model_w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < model_nw; i++) begin
      t = model_w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      model_w[i] = model_w[i-nk] ^ t;
    end
  endtask

  task automatic run_expand(input logic [1:0] m, input logic [255:0] k,
                            input int lat, input int nw, input string nm);
    int n;
    mode = m; key = k; start = 1'b1;
    tick;
    start = 1'b0;
    chk({nm, " busy_after_start"}, 32'(busy), 32'd1);
    chk({nm, " rk_valid_after_start"}, 32'(rk_valid), 32'd0);
    chk({nm, " num_words"}, 32'(num_words), 32'(nw));
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(lat));
    chk({nm, " busy_at_done"}, 32'(busy), 32'd0);
    chk({nm, " rk_valid_at_done"}, 32'(rk_valid), 32'd1);
    tick;
    chk({nm, " done_one_cycle"}, 32'(done), 32'd0);
    chk({nm, " rk_valid_holds"}, 32'(rk_valid), 32'd1);
  endtask

  task automatic read_word(input int a, input logic [31:0] exp, input string nm);
    rk_addr = a[5:0];
    tick;
    chk($sformatf("%s w[%0d]", nm, a), rk_word, exp);
  endtask

  // Scoreboarded read sweep over the whole address space
  task automatic sweep(input string nm);
    logic [31:0] e;
    for (int a = 0; a < 64; a++) begin
      rk_addr = a[5:0];
      sb_q.push_back((a < model_nw) ? model_w[a] : 32'h0);
      tick;
      e = sb_q.pop_front();
      chk($sformatf("%s sweep addr=%0d", nm, a), rk_word, e);
    end
  endtask

  initial begin
    int n;
    int done_seen;
    int busy_seen;

    vecs[0] = '{2'd0, K128, 40, 44, 0, 32'h2b7e1516, 4,  32'ha0fafe17, 43, 32'hb6630ca6};
    vecs[1] = '{2'd1, K192, 46, 52, 0, 32'h8e73b0f7, 6,  32'hfe0c91f7, 51, 32'h01002202};
    vecs[2] = '{2'd2, K256, 52, 60, 8, 32'h9ba35411, 12, 32'ha8b09c1a, 59, 32'h706c631e};

    build_sbox;

    rst = 1'b1; start = 1'b0; mode = 2'd0; key = '0; rk_addr = 6'd0;
    tick;
    tick;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset rk_valid", 32'(rk_valid), 32'd0);
    chk("reset num_words", 32'(num_words), 32'd44);
    chk("reset rk_word", rk_word, 32'h0);
    rst = 1'b0;
    tick;

    // Known-answer vectors for each key size
    for (int v = 0; v < 3; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      run_expand(vecs[v].mode, vecs[v].key, vecs[v].lat, vecs[v].nw, nm);
      read_word(vecs[v].a0, vecs[v].w0, nm);
      read_word(vecs[v].a1, vecs[v].w1, nm);
      read_word(vecs[v].a2, vecs[v].w2, nm);
      build_model(vecs[v].mode, vecs[v].key);
      sweep(nm);
    end

    // Reserved mode: err pulse, no state change
    mode = 2'd3; key = K128; start = 1'b1;
    tick;
    start = 1'b0;
    chk("mode3 err", 32'(err), 32'd1);
    chk("mode3 busy", 32'(busy), 32'd0);
    chk("mode3 rk_valid", 32'(rk_valid), 32'd1);
    chk("mode3 num_words", 32'(num_words), 32'd60);
    tick;
    chk("mode3 err_one_cycle", 32'(err), 32'd0);
    chk("mode3 busy_later", 32'(busy), 32'd0);

    // Second start mid-expansion with new key/mode must be ignored
    mode = 2'd0; key = K128; start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (n == 5) begin
        start = 1'b1; mode = 2'd2; key = K256;
      end else begin
        start = 1'b0;
      end
      tick;
      n++;
      if (err === 1'b1) chk("ignored_start err", 32'(err), 32'd0);
    end
    start = 1'b0;
    chk("ignored_start latency", 32'(n), 32'd40);
    chk("ignored_start num_words", 32'(num_words), 32'd44);
    build_model(2'd0, K128);
    sweep("ignored_start");

    // Abort an AES-256 expansion with rst 20 edges after the start edge
    mode = 2'd2; key = K256; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    rk_addr = 6'd8;
    tick;
    chk("midexp read w[8]", rk_word, 32'h9ba35411);
    chk("midexp rk_valid", 32'(rk_valid), 32'd0);
    repeat (14) tick;
    rst = 1'b1;
    tick;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rk_valid", 32'(rk_valid), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    start = 1'b1; mode = 2'd0;
    tick;
    start = 1'b0;
    chk("rst_wins busy", 32'(busy), 32'd0);
    rst = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    for (int c = 0; c < 60; c++) begin
      tick;
      if (done === 1'b1) done_seen++;
      if (busy === 1'b1) busy_seen++;
    end
    chk("abort no_done", 32'(done_seen), 32'd0);
    chk("abort no_busy", 32'(busy_seen), 32'd0);

    // Fresh AES-128 after the abort
    run_expand(2'd0, K128, 40, 44, "post_abort");
    read_word(43, 32'hb6630ca6, "post_abort");
    build_model(2'd0, K128);
    sweep("post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative, clocked AES key-schedule engine. Generalises the combinational AES-128 expansion to runtime-selectable AES-128, AES-192 and AES-256.
- Produces one round-key word per cycle into an internal round-key store.
- The store is read back through a registered address/data port by the round datapath.
- Sits between the key-load interface and the cipher core. Replaces the flat 44-word combinational output with a compact read port.

Parameters:
- MAX_WORDS, 60, depth of the round-key store in 32-bit words. Must be >= 60 to support AES-256.
- ADDR_W, 6, width of rk_addr. Must satisfy 2**ADDR_W >= MAX_WORDS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin expansion; sampled only in IDLE
- mode  in  2  key size: 0 = AES-128 (Nk=4), 1 = AES-192 (Nk=6), 2 = AES-256 (Nk=8), 3 = reserved
- key  in  256  cipher key in FIPS-197 byte order; first key byte in key[255:248]; Nk*32 MSBs used, remaining LSBs ignored
- busy  out  1  high while expansion is in progress
- done  out  1  one-cycle pulse when the final word is written
- err  out  1  one-cycle pulse when start is accepted with mode = 3
- rk_valid  out  1  round-key store is complete and consistent with the last key
- num_words  out  6  total words for the latched mode: 44, 52 or 60
- rk_addr  in  ADDR_W  round-key word read address
- rk_word  out  32  registered read data: store[rk_addr] one cycle after rk_addr is presented

Behaviour:
- Reset values: busy, done, err, rk_valid, rk_word = 0; num_words = 44; state IDLE. Store contents are not reset and are don't-care while rk_valid = 0.
- States:
  - IDLE. Start with mode 0..2 goes to EXPAND. Start with mode 3 pulses err and stays in IDLE.
  - EXPAND. Returns to IDLE on the edge that writes the final word.
- Start edge E0 (IDLE, legal mode):
  - Latch mode and Nk.
  - Write w[0..Nk-1] from key, with w[0] = key[255:224].
  - Set word index i = Nk and rcon = 8'h01.
  - busy = 1, rk_valid = 0. num_words is updated.
- Each EXPAND edge writes exactly one word: w[i] = w[i-Nk] ^ t, where t is chosen as follows:
  - i mod Nk == 0: t = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}; then rcon = xtime(rcon). Rcon is generated, not tabled: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Nk == 8 and i mod 8 == 4: t = SubWord(w[i-1]).
  - otherwise: t = w[i-1].
- Index tracking: track i mod Nk with a wrap counter; no divider.
- RotWord rotates left by one byte. SubWord applies the AES S-box to each byte, using 4 S-box instances shared across both SubWord cases.
- Latency: expansion writes are (num_words - Nk) edges after E0 (40 for AES-128, 46 for AES-192, 52 for AES-256).
- On the final write edge:
  - done = 1 for one cycle.
  - busy = 0.
  - rk_valid = 1; it stays high until the next accepted start or rst.
- start while busy: ignored; no restart, no err.
- rk_addr >= num_words: rk_word = 0.
- Reads during EXPAND are allowed. Words already written return their final values; rk_valid stays 0.
- Simultaneous read of the word being written on the same edge returns the old content; write-through is not required.
- rst mid-expansion: abort on that edge and go to IDLE. busy, done and rk_valid = 0. A later start re-expands from scratch.
- start and rst on the same edge: rst wins.
- A key or mode change while busy has no effect; both are latched only at E0.

Test Plan:
- AES-128, key 2b7e1516_28aed2a6_abf71588_09cf4f3c -> done exactly 40 cycles after the start edge; w[4] = a0fafe17, w[43] = b6630ca6; num_words = 44.
- AES-192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> done after 46 cycles; w[6] = fe0c91f7, w[51] = 01002202.
- AES-256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> done after 52 cycles; w[8] = 9ba35411, w[12] = a8b09c1a (the SubWord-only case), w[59] = 706c631e.
- Assert start with mode = 3 -> err pulses one cycle; busy stays 0; rk_valid unchanged. A second start during an AES-128 expansion is ignored; done still arrives at cycle 40.
- Assert rst at cycle 20 of an AES-256 expansion -> next cycle busy = 0, rk_valid = 0, no done pulse. A fresh AES-128 start then completes correctly.
- Sweep rk_addr 0..63 after each mode -> rk_word matches a software model with 1-cycle latency; addresses >= num_words read 0.
